// File: rtl/serial_link.sv
// Serial link controller: SB (FF01) shift register and SC (FF02) control,
// clocked either by the internal divider tick or by the synchronized sck pad.
module serial_link #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk1,
   input  logic       nreset,
   input  logic       sclk_tick,
   input  logic       ff01,
   input  logic       ff02,
   input  logic       cpu_wr,
   input  logic       cpu_rd,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   input  logic       sin,
   input  logic       sck_in,
   output logic       sout,
   output logic       sck_out,
   output logic       sck_dir,
   output logic       ser_out,
   output logic       int_serial
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] XFER_INT = 2'd1;
   localparam logic [1:0] XFER_EXT = 2'd2;

   logic [7:0]             sb;
   logic                   sc_start;
   logic                   sc_clk;
   logic [2:0]             cnt;
   logic                   phase;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] sin_sync;
   logic                   sck_prev;
   logic [1:0]             state;

   logic sck_s, sin_s;
   logic sb_wr, sc_wr;
   logic int_fall, int_rise, ext_fall, ext_rise;
   logic shift_out, shift_in;
   logic [3:0] cnt_next;

   assign state = !sc_start ? IDLE : (sc_clk ? XFER_INT : XFER_EXT);

   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign sin_s = sin_sync[SYNC_STAGES-1];

   assign sb_wr = cpu_wr & ff01;
   assign sc_wr = cpu_wr & ff02 & ~ff01;

   assign int_fall = (state == XFER_INT) & sclk_tick &  phase;
   assign int_rise = (state == XFER_INT) & sclk_tick & ~phase;
   assign ext_fall = (state == XFER_EXT) &  sck_prev & ~sck_s;
   assign ext_rise = (state == XFER_EXT) & ~sck_prev &  sck_s;

   assign shift_out = int_fall | ext_fall;
   assign shift_in  = int_rise | ext_rise;

   // Carry out of the 3-bit bit counter marks the eighth shift.
   assign cnt_next = {1'b0, cnt} + 4'd1;

   assign sck_dir = sc_clk;
   assign ser_out = sout;

   always_comb begin
      // NOTE: default first so every path assigns d_out and no latch is inferred.
      d_out = 8'hFF;
      if (cpu_rd && ff01)      d_out = sb;
      else if (cpu_rd && ff02) d_out = {sc_start, 6'b111111, sc_clk};
   end

   always_ff @(posedge clk1) begin
      if (!nreset) begin
         sck_sync <= '1;
         sin_sync <= '1;
         sck_prev <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
         sin_sync <= {sin_sync[SYNC_STAGES-2:0], sin};
         sck_prev <= sck_s;
      end
   end

   always_ff @(posedge clk1) begin
      if (!nreset) begin
         sb         <= 8'h00;
         sc_start   <= 1'b0;
         sc_clk     <= 1'b0;
         cnt        <= 3'd0;
         phase      <= 1'b1;
         sout       <= 1'b1;
         sck_out    <= 1'b1;
         int_serial <= 1'b0;
      end else begin
         int_serial <= 1'b0;

         // An SC write overrides any edge landing in the same cycle.
         if (sc_wr) begin
            sc_clk   <= d_in[0];
            sc_start <= d_in[7];
            cnt      <= 3'd0;
            phase    <= 1'b1;
            sck_out  <= 1'b1;
         end else begin
            if (shift_out) sout <= sb[7];
            if (int_fall) begin
               sck_out <= 1'b0;
               phase   <= 1'b0;
            end
            if (int_rise) begin
               sck_out <= 1'b1;
               phase   <= 1'b1;
            end
            if (shift_in) begin
               cnt <= cnt_next[2:0];
               if (cnt_next[3]) begin
                  sc_start   <= 1'b0;
                  int_serial <= 1'b1;
               end
            end
         end

         // A CPU load of SB wins over a shift; the count still advances.
         if (sb_wr)                 sb <= d_in;
         else if (shift_in && !sc_wr) sb <= {sb[6:0], sin_s};
      end
   end

endmodule
